// File: rtl/corefifo_wr_ptr_ctrl.sv
// Write-domain pointer and flag controller for the async CoreFIFO.
// Synchronizes the read-domain gray pointer, decodes it to binary, and
// maintains the write pointers, memory write strobe, fill level and flags.

// Gray-to-binary converter shared by both FIFO domains.
module corefifo_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all gray bits at or above its position.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves bin unassigned and infers a latch.
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

module corefifo_wr_ptr_ctrl #(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH:0]   rptr_gray_in,
  output logic [ADDRWIDTH:0]   wptr_gray,
  output logic [ADDRWIDTH-1:0] waddr,
  output logic                 mem_we,
  output logic [ADDRWIDTH:0]   wr_level,
  output logic                 full,
  output logic                 afull,
  output logic                 overflow
);

  localparam int PTRW  = ADDRWIDTH + 1;
  localparam int DEPTH = 1 << ADDRWIDTH;

  localparam logic [PTRW-1:0] LEVEL_FULL  = PTRW'(DEPTH);
  localparam logic [PTRW-1:0] LEVEL_AFULL = PTRW'(AFULL_THRESH);

  logic [PTRW-1:0] rptr_gray_meta;
  logic [PTRW-1:0] rptr_gray_sync;
  logic [PTRW-1:0] rptr_bin;
  logic [PTRW-1:0] wptr_bin;
  logic [PTRW-1:0] wptr_bin_next;
  logic [PTRW-1:0] wptr_gray_next;
  logic [PTRW-1:0] level_next;
  logic            accept;

  // Two-flop synchronizer bringing the read pointer into the write domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_gray_meta <= '0;
      rptr_gray_sync <= '0;
    end else begin
      // NOTE: non-blocking so both stages sample the pre-edge values and form a real two-stage chain.
      rptr_gray_meta <= rptr_gray_in;
      rptr_gray_sync <= rptr_gray_meta;
    end
  end

  corefifo_gray2bin #(
    .WIDTH (PTRW)
  ) u_rptr_g2b (
    .gray (rptr_gray_sync),
    .bin  (rptr_bin)
  );

  // A write is taken only when not full and not held in reset, so reset drops any in-flight write.
  assign accept = wr_en & ~full & ~rst;
  assign mem_we = accept;
  assign waddr  = wptr_bin[ADDRWIDTH-1:0];

  // Next pointer, its gray code, and the fill level that would result.
  // Modular arithmetic handles wrap-around of either pointer with no special case.
  always_comb begin
    wptr_bin_next  = wptr_bin + {{(PTRW-1){1'b0}}, accept};
    wptr_gray_next = wptr_bin_next ^ (wptr_bin_next >> 1);
    level_next     = wptr_bin_next - rptr_bin;
  end

  // Pointer, level and flag registers; wptr_gray is only ever a register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
      wr_level  <= '0;
      full      <= 1'b0;
      afull     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wptr_bin  <= wptr_bin_next;
      wptr_gray <= wptr_gray_next;
      wr_level  <= level_next;
      full      <= (level_next == LEVEL_FULL);
      afull     <= (level_next >= LEVEL_AFULL);
      overflow  <= wr_en & full;
    end
  end

endmodule

// File: tb/tb_corefifo_wr_ptr_ctrl.sv
// Directed testbench for corefifo_wr_ptr_ctrl with ADDRWIDTH=3, AFULL_THRESH=6.
module tb_corefifo_wr_ptr_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] rptr_gray_in;
  logic [3:0] wptr_gray;
  logic [2:0] waddr;
  logic       mem_we;
  logic [3:0] wr_level;
  logic       full;
  logic       afull;
  logic       overflow;

  int n_cmp;
  int n_err;

  corefifo_wr_ptr_ctrl #(
    .ADDRWIDTH    (3),
    .AFULL_THRESH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rptr_gray_in (rptr_gray_in),
    .wptr_gray    (wptr_gray),
    .waddr        (waddr),
    .mem_we       (mem_we),
    .wr_level     (wr_level),
    .full         (full),
    .afull        (afull),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b1;
    rptr_gray_in = 4'b0101;
    step();
    step();
    n_cmp++;
    if ({wptr_gray, waddr, mem_we, wr_level, full, afull, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: gray=%b waddr=%0d we=%b lvl=%0d full=%b afull=%b ovf=%b, required all 0",
               wptr_gray, waddr, mem_we, wr_level, full, afull, overflow);
    end
    wr_en = 1'b0;
    rptr_gray_in = 4'b0000;
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (wr_level !== 4'd0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: lvl=%0d full=%b, required lvl=0 full=0", wr_level, full);
    end
  endtask

  task automatic test_fill();
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (waddr !== 3'(i) || mem_we !== 1'b1) begin
        n_err++;
        $display("FAIL fill_waddr[%0d]: waddr=%0d we=%b, required waddr=%0d we=1", i, waddr, mem_we, i);
      end
      step();
      n_cmp++;
      if (wr_level !== 4'(i + 1) || afull !== (i + 1 >= 6) || full !== (i + 1 == 8)) begin
        n_err++;
        $display("FAIL fill_flags[%0d]: lvl=%0d afull=%b full=%b, required lvl=%0d afull=%b full=%b",
                 i, wr_level, afull, full, i + 1, (i + 1 >= 6), (i + 1 == 8));
      end
    end
    wr_en = 1'b0;
    n_cmp++;
    if (wptr_gray !== 4'b1100) begin
      n_err++;
      $display("FAIL fill_gray: wptr_gray=%b, required 1100", wptr_gray);
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL ovf_we[%0d]: mem_we=%b, required 0", i, mem_we);
      end
      step();
      n_cmp++;
      if (overflow !== 1'b1 || wptr_gray !== 4'b1100) begin
        n_err++;
        $display("FAIL ovf_pulse[%0d]: ovf=%b gray=%b, required ovf=1 gray=1100", i, overflow, wptr_gray);
      end
    end
    wr_en = 1'b0;
    step();
    n_cmp++;
    if (overflow !== 1'b0 || wptr_gray !== 4'b1100) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%b gray=%b, required ovf=0 gray=1100", overflow, wptr_gray);
    end
  endtask

  task automatic test_read_sync();
    rptr_gray_in = 4'b0010;
    for (int e = 1; e <= 2; e++) begin
      step();
      n_cmp++;
      if (full !== 1'b1) begin
        n_err++;
        $display("FAIL sync_hold[edge %0d]: full=%b, required 1", e, full);
      end
    end
    step();
    n_cmp++;
    if (full !== 1'b0 || afull !== 1'b0 || wr_level !== 4'd5) begin
      n_err++;
      $display("FAIL sync_update: full=%b afull=%b lvl=%0d, required full=0 afull=0 lvl=5", full, afull, wr_level);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    w = 4'd8;
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rptr_gray_in = to_gray(w - 4'd2);
      #1;
      n_cmp++;
      if (mem_we !== 1'b1 || waddr !== w[2:0] || full !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_we[%0d]: we=%b waddr=%0d full=%b, required we=1 waddr=%0d full=0",
                 i, mem_we, waddr, full, w[2:0]);
      end
      step();
      w = w + 4'd1;
      n_cmp++;
      if (wptr_gray !== to_gray(w) || full !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_gray[%0d]: gray=%b full=%b, required gray=%b full=0", i, wptr_gray, full, to_gray(w));
      end
    end
    wr_en = 1'b0;
    rptr_gray_in = to_gray(w - 4'd2);
    step();
    step();
    step();
    n_cmp++;
    if (wr_level !== 4'd2 || full !== 1'b0 || afull !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_settle: lvl=%0d full=%b afull=%b, required lvl=2 full=0 afull=0", wr_level, full, afull);
    end
  endtask

  task automatic test_reset_mid_burst();
    rst = 1'b1;
    rptr_gray_in = 4'b0000;
    step();
    rst = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (waddr !== 3'd5 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_setup: waddr=%0d we=%b, required waddr=5 we=1", waddr, mem_we);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({wptr_gray, waddr, mem_we, wr_level, full, afull, overflow} !== '0) begin
      n_err++;
      $display("FAIL midrst_clear: gray=%b waddr=%0d we=%b lvl=%0d full=%b afull=%b ovf=%b, required all 0",
               wptr_gray, waddr, mem_we, wr_level, full, afull, overflow);
    end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (waddr !== 3'd0 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_first: waddr=%0d we=%b, required waddr=0 we=1", waddr, mem_we);
    end
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (wptr_gray !== 4'b0001 || wr_level !== 4'd1) begin
      n_err++;
      $display("FAIL midrst_after: gray=%b lvl=%0d, required gray=0001 lvl=1", wptr_gray, wr_level);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    rptr_gray_in = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_read_sync();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/corefifo_wr_ptr_ctrl.md
Name: corefifo_wr_ptr_ctrl

Overview:
Write-domain pointer and flag controller for the async CoreFIFO. It synchronizes the read-domain gray pointer and converts it to binary through the existing gray-to-binary converter, which it instantiates. It maintains the binary and gray write pointers and generates the memory write strobe, write address, fill level, full, almost-full and overflow flags. The registered gray write pointer is the value the read domain synchronizes and decodes.

Parameters:
ADDRWIDTH, 3, memory address width; FIFO depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits; legal range is 2 or more.
AFULL_THRESH, 6, almost-full asserts when the fill level is at least this value; legal range is 1 to 2^ADDRWIDTH.

Ports:
clk  in  1  write-domain clock
rst  in  1  asynchronous active-high reset
wr_en  in  1  write request
rptr_gray_in  in  ADDRWIDTH+1  read pointer, gray coded, from the read domain (asynchronous)
wptr_gray  out  ADDRWIDTH+1  registered gray write pointer, to the read domain
waddr  out  ADDRWIDTH  memory write address
mem_we  out  1  memory write strobe
wr_level  out  ADDRWIDTH+1  registered fill level as seen by the write side
full  out  1  registered full flag
afull  out  1  registered almost-full flag
overflow  out  1  one-cycle pulse when a write is attempted while full

Behaviour:
- Reset: clk and rst are fixed as above (one clock; rst asynchronous, active-high). Asserting rst clears both sync stages, wptr_bin, wptr_gray, wr_level, full, afull and overflow to 0 immediately. Writes are ignored while rst is high.
- Read pointer sync: a two-flop synchronizer on rptr_gray_in produces rptr_gray_sync. The converter produces rptr_bin from rptr_gray_sync combinationally.
- Write acceptance: accept = wr_en & ~full.
  - mem_we = accept (combinational, same cycle).
  - waddr = wptr_bin[ADDRWIDTH-1:0] (combinational from the register).
- Pointer update: wptr_bin_next = wptr_bin + accept, modulo 2^(ADDRWIDTH+1). This wraps from all-ones to 0.
  - wptr_gray is registered from wptr_bin_next ^ (wptr_bin_next >> 1).
  - wptr_gray is never driven combinationally, so at most one bit changes per clk edge.
- Level: level_next = (wptr_bin_next - rptr_bin), modulo 2^(ADDRWIDTH+1), and is registered into wr_level. The value never exceeds 2^ADDRWIDTH in legal operation.
- Flags, all registered from level_next:
  - full = (level_next == 2^ADDRWIDTH)
  - afull = (level_next >= AFULL_THRESH)
  - overflow = wr_en & full (one cycle later; the pointer and memory are untouched).
- Latency:
  - A write accepted in cycle N updates wptr_gray, wr_level and flags at edge N+1.
  - A change on rptr_gray_in is reflected in wr_level and full at the third clk edge after it is captured (2 sync stages plus 1 flag register).
  - Full deassertion is therefore pessimistic, never optimistic.
- Boundaries:
  - Write on the last free slot asserts full in the next cycle. A back-to-back write in that next cycle is rejected.
  - Simultaneous write and read-pointer advance: the level is computed from both, so it stays unchanged.
  - A write while full produces no pointer change and no mem_we.
  - Wrap-around of either pointer needs no special case because of the modular subtraction.
  - Reset mid-burst drops the in-flight write. mem_we is low during rst.

Test Plan:
1. Assert rst with wr_en=1 and rptr_gray_in=4'b0101 -> all outputs 0 and mem_we=0 while rst is high. After release, wr_level=0 and full=0.
2. ADDRWIDTH=3, rptr_gray_in=0, 8 consecutive writes -> waddr runs 0..7 with mem_we=1 each cycle; afull=1 after the 6th write; full=1 and wr_level=8 after the 8th; wptr_gray=4'b1100.
3. While full, hold wr_en=1 for 2 cycles -> mem_we=0, wptr_gray stays 4'b1100, overflow=1 for each of the 2 cycles (lagging by one cycle), then 0.
4. From full, set rptr_gray_in=4'b0010 (binary 3) -> full=0, afull=0 and wr_level=5 exactly 3 clk edges later. full stays 1 before that.
5. Continuous writes with rptr tracking 2 behind, 20 writes -> wptr_bin wraps 15->0 (wptr_gray goes 1000->0000), full never asserts, wr_level settles at 2 once the pipeline fills.
6. Assert rst asynchronously mid-burst with wptr at 5 -> outputs clear before the next clk edge. The first write after release goes to waddr=0.
